shift_tx: RTL and testbench

- Parallel-to-serial transmitter: the sending end of the counter family's serial shift-in path (SHL/SHR feeding D[0]/D[N-1]).
- Accepts an N-bit word over a valid/ready handshake, then drives it out one bit at a time, MSB-first or LSB-first.
- Each bit is held DIV clocks; a one-cycle strobe marks the sample point, so SO and SHE connect directly to a receiver's serial data input and shift-enable.
- Sits between a parallel data source and a shift-register/counter receiver on the same clock.

---
 rtl/shift_tx.sv | 110 +++++++++++
 tb/tb_shift_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_tx.sv
// Parallel-to-serial transmitter: accepts an N-bit word on START/READY and shifts it out
// MSB- or LSB-first, holding each bit DIV clocks with a one-cycle SHE sample strobe.
module shift_tx #(
  parameter int unsigned N   = 4,
  parameter int unsigned DIV = 4
) (
  input  logic         C,
  input  logic         R,
  input  logic [N-1:0] D,
  input  logic         START,
  input  logic         DIR,
  input  logic         ABORT,
  output logic         READY,
  output logic         BUSY,
  output logic         SO,
  output logic         SHE,
  output logic         DONE
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_sreg;
  logic [N-1:0]   w_sreg_nxt;
  logic [DW-1:0]  r_div;
  logic [DW-1:0]  w_div_nxt;
  logic [BW-1:0]  r_bit;
  logic [BW-1:0]  w_bit_nxt;
  logic           r_dir;
  logic           w_dir_nxt;
  logic           r_done;
  logic           w_done_nxt;
  logic           w_she;

  // Strobe and serial data are pure decodes of registered state, so they are glitch-free.
  assign w_she = (r_state == SHIFT) && (r_div == DW'(DIV - 1));
  assign READY = (r_state == IDLE);
  assign BUSY  = (r_state == SHIFT);
  assign SHE   = w_she;
  assign DONE  = r_done;
  assign SO    = (r_state == SHIFT) ? (r_dir ? r_sreg[0] : r_sreg[N-1]) : 1'b0;

  // State and datapath registers
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_div   <= '0;
      r_bit   <= '0;
      r_dir   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sreg  <= w_sreg_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_dir   <= w_dir_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state: ABORT beats the final strobe; START during SHIFT is dropped, not queued.
  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_dir_nxt   = r_dir;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (START && !ABORT) begin
          w_state_nxt = SHIFT;
          w_sreg_nxt  = D;
          w_dir_nxt   = DIR;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
        end
      end
      SHIFT: begin
        if (ABORT) begin
          w_state_nxt = IDLE;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
        end else if (w_she) begin
          w_div_nxt = '0;
          if (r_bit == BW'(N - 1)) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt  = r_bit + BW'(1);
            w_sreg_nxt = r_dir ? {1'b0, r_sreg[N-1:1]} : {r_sreg[N-2:0], 1'b0};
          end
        end else begin
          w_div_nxt = r_div + DW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_tx.sv
// Self-checking bench for shift_tx: N=4/DIV=4 main instance plus a DIV=1 instance,
// with a scoreboard queue of expected serial bits popped on every SHE.
module tb_shift_tx;

  logic       C;
  logic       R;
  logic [3:0] D;
  logic       START, DIR, ABORT;
  logic       READY, BUSY, SO, SHE, DONE;
  logic [3:0] D1;
  logic       START1, DIR1, ABORT1;
  logic       READY1, BUSY1, SO1, SHE1, DONE1;

  int   n_checks = 0;
  int   n_errors = 0;
  logic sb_q[$];

  logic       rx_clr;
  logic [3:0] rx_shl, rx_shr;

  shift_tx #(.N(4), .DIV(4)) dut (
    .C(C), .R(R), .D(D), .START(START), .DIR(DIR), .ABORT(ABORT),
    .READY(READY), .BUSY(BUSY), .SO(SO), .SHE(SHE), .DONE(DONE)
  );

  shift_tx #(.N(4), .DIV(1)) dut1 (
    .C(C), .R(R), .D(D1), .START(START1), .DIR(DIR1), .ABORT(ABORT1),
    .READY(READY1), .BUSY(BUSY1), .SO(SO1), .SHE(SHE1), .DONE(DONE1)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // Receiving shift registers: SHL takes SO into bit 0, SHR takes SO into bit 3.
  always @(posedge C) begin
    if (rx_clr) begin
      rx_shl <= 4'b0;
      rx_shr <= 4'b0;
    end else if (SHE) begin
      rx_shl <= {rx_shl[2:0], SO};
      rx_shr <= {SO, rx_shr[3:1]};
    end
  end

  task automatic test_reset();
    logic [4:0] got;
    R = 1'b1; D = 4'h0; START = 0; DIR = 0; ABORT = 0;
    D1 = 4'h0; START1 = 0; DIR1 = 0; ABORT1 = 0; rx_clr = 1'b1;
    #3;
    got = {READY, BUSY, SO, SHE, DONE};
    n_checks++;
    if (got !== 5'b10000) begin n_errors++; $display("FAIL reset_main got=%b exp=10000", got); end
    got = {READY1, BUSY1, SO1, SHE1, DONE1};
    n_checks++;
    if (got !== 5'b10000) begin n_errors++; $display("FAIL reset_div1 got=%b exp=10000", got); end
    @(negedge C); @(negedge C);
    R = 1'b0; rx_clr = 1'b0;
    @(negedge C);
    got = {READY, BUSY, SO, SHE, DONE};
    n_checks++;
    if (got !== 5'b10000) begin n_errors++; $display("FAIL reset_release got=%b exp=10000", got); end
  endtask

  task automatic test_frames();
    logic [3:0] w;
    logic [4:0] got, exp_v;
    logic       exp_so, exp_bit;
    w = 4'b1011;
    for (int d = 0; d < 2; d++) begin
      @(negedge C); D = w; DIR = d[0]; START = 1'b1;
      for (int i = 0; i < 4; i++) sb_q.push_back((d == 0) ? w[3-i] : w[i]);
      @(negedge C); START = 1'b0; D = ~w; DIR = ~DIR;
      for (int c = 1; c <= 17; c++) begin
        exp_so = (c <= 16) ? ((d == 0) ? w[3-(c-1)/4] : w[(c-1)/4]) : 1'b0;
        exp_v  = {c > 16, c <= 16, exp_so, (c % 4 == 0) && (c <= 16), c == 17};
        got    = {READY, BUSY, SO, SHE, DONE};
        n_checks++;
        if (got !== exp_v) begin
          n_errors++; $display("FAIL frame dir=%0d c=%0d got=%b exp=%b", d, c, got, exp_v);
        end
        if (SHE) begin
          n_checks++;
          if (sb_q.size() == 0) begin n_errors++; $display("FAIL sb_underflow frame c=%0d", c); end
          else begin
            exp_bit = sb_q.pop_front();
            if (SO !== exp_bit) begin n_errors++; $display("FAIL sb_bit frame c=%0d got=%b exp=%b", c, SO, exp_bit); end
          end
        end
        if (c < 17) @(negedge C);
      end
    end
    n_checks++;
    if (sb_q.size() != 0) begin n_errors++; $display("FAIL sb_leftover frames got=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_loopback();
    logic [3:0] w;
    w = 4'b0110;
    for (int d = 0; d < 2; d++) begin
      @(negedge C); rx_clr = 1'b1;
      @(negedge C); rx_clr = 1'b0; D = w; DIR = d[0]; START = 1'b1;
      @(negedge C); START = 1'b0;
      for (int c = 1; c <= 17; c++) begin
        if (c == 9 && d == 0) begin
          n_checks++;
          if (rx_shl !== 4'b0001) begin n_errors++; $display("FAIL loop_shl_mid got=%b exp=0001", rx_shl); end
        end
        if (c == 17) begin
          n_checks++;
          if (d == 0 && rx_shl !== w) begin n_errors++; $display("FAIL loop_shl got=%b exp=%b", rx_shl, w); end
          if (d == 1 && rx_shr !== w) begin n_errors++; $display("FAIL loop_shr got=%b exp=%b", rx_shr, w); end
        end
        if (c < 17) @(negedge C);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] got, exp_v;
    logic       exp_bit;
    int         dones;
    dones = 0;
    @(negedge C); D = 4'hA; DIR = 1'b0; START = 1'b1;
    sb_q.push_back(1); sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(0);
    sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(0); sb_q.push_back(1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge C);
      if (c == 17) D = 4'h5;
      if (c == 18) START = 1'b0;
      if (c == 25) START = 1'b1;
      if (c == 26) START = 1'b0;
      exp_v = {(c <= 16) || (c >= 18 && c <= 33), (c == 17) || (c == 34)};
      got   = {BUSY, DONE};
      if (DONE) dones++;
      n_checks++;
      if (got !== exp_v) begin n_errors++; $display("FAIL b2b c=%0d busy_done got=%b exp=%b", c, got, exp_v); end
      if (SHE) begin
        n_checks++;
        if (sb_q.size() == 0) begin n_errors++; $display("FAIL sb_underflow b2b c=%0d", c); end
        else begin
          exp_bit = sb_q.pop_front();
          if (SO !== exp_bit) begin n_errors++; $display("FAIL sb_bit b2b c=%0d got=%b exp=%b", c, SO, exp_bit); end
        end
      end
    end
    n_checks++;
    if (dones != 2 || sb_q.size() != 0) begin
      n_errors++; $display("FAIL b2b_totals dones=%0d left=%0d exp 2/0", dones, sb_q.size());
    end
  endtask

  task automatic test_abort();
    logic [4:0] got;
    logic       exp_bit;
    logic [3:0] w;
    int         ab;
    @(negedge C); D = 4'hF; START = 1'b1; ABORT = 1'b1;
    @(negedge C); START = 1'b0; ABORT = 1'b0;
    got = {READY, BUSY, SO, SHE, DONE};
    n_checks++;
    if (got !== 5'b10000) begin n_errors++; $display("FAIL abort_idle_block got=%b exp=10000", got); end
    w = 4'b1101;
    for (int k = 0; k < 2; k++) begin
      ab = (k == 0) ? 6 : 16;
      @(negedge C); D = w; DIR = 1'b0; START = 1'b1;
      sb_q.push_back(w[3]);
      if (ab == 16) begin sb_q.push_back(w[2]); sb_q.push_back(w[1]); sb_q.push_back(w[0]); end
      for (int c = 1; c <= ab + 4; c++) begin
        @(negedge C);
        START = 1'b0;
        ABORT = (c == ab);
        got = {READY, BUSY, SO, SHE, DONE};
        if (c > ab) begin
          n_checks++;
          if (got !== 5'b10000) begin n_errors++; $display("FAIL abort_at%0d c=%0d got=%b exp=10000", ab, c, got); end
        end
        if (SHE) begin
          n_checks++;
          if (sb_q.size() == 0) begin n_errors++; $display("FAIL sb_underflow abort c=%0d", c); end
          else begin
            exp_bit = sb_q.pop_front();
            if (SO !== exp_bit) begin n_errors++; $display("FAIL sb_bit abort c=%0d got=%b exp=%b", c, SO, exp_bit); end
          end
        end
      end
    end
    // A clean frame after the aborts must run normally.
    @(negedge C); D = 4'b0111; DIR = 1'b1; START = 1'b1;
    sb_q.push_back(1); sb_q.push_back(1); sb_q.push_back(1); sb_q.push_back(0);
    for (int c = 1; c <= 17; c++) begin
      @(negedge C);
      START = 1'b0;
      n_checks++;
      if (DONE !== (c == 17)) begin n_errors++; $display("FAIL post_abort_done c=%0d got=%b", c, DONE); end
      if (SHE) begin
        n_checks++;
        if (sb_q.size() == 0) begin n_errors++; $display("FAIL sb_underflow post_abort c=%0d", c); end
        else begin
          exp_bit = sb_q.pop_front();
          if (SO !== exp_bit) begin n_errors++; $display("FAIL sb_bit post_abort c=%0d got=%b exp=%b", c, SO, exp_bit); end
        end
      end
    end
    n_checks++;
    if (sb_q.size() != 0) begin n_errors++; $display("FAIL sb_leftover abort got=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_async_reset();
    logic [4:0] got;
    @(negedge C); D = 4'b0010; DIR = 1'b0; START = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge C);
      START = 1'b0;
    end
    n_checks++;
    if ({BUSY, SO} !== 2'b11) begin n_errors++; $display("FAIL pre_reset busy_so got=%b exp=11", {BUSY, SO}); end
    #2 R = 1'b1;
    #1 got = {READY, BUSY, SO, SHE, DONE};
    n_checks++;
    if (got !== 5'b10000) begin n_errors++; $display("FAIL async_reset got=%b exp=10000", got); end
    @(negedge C); R = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge C);
      got = {READY, BUSY, SO, SHE, DONE};
      n_checks++;
      if (got !== 5'b10000) begin n_errors++; $display("FAIL post_reset c=%0d got=%b exp=10000", c, got); end
    end
  endtask

  task automatic test_div1();
    logic [3:0] w;
    logic [4:0] got, exp_v;
    w = 4'b1001;
    @(negedge C); D1 = w; DIR1 = 1'b0; START1 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge C);
      START1 = 1'b0;
      exp_v = {c > 4, c <= 4, (c <= 4) ? w[4-c] : 1'b0, c <= 4, c == 5};
      got   = {READY1, BUSY1, SO1, SHE1, DONE1};
      n_checks++;
      if (got !== exp_v) begin n_errors++; $display("FAIL div1 c=%0d got=%b exp=%b", c, got, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_loopback();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_div1();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
